// File: rtl/registr_decode_if.sv
// Decode request/response bundle between the receive-side consumer and the divider.
interface registr_decode_if #(
   parameter int WIDTH_IN  = 8,
   parameter int WIDTH_OUT = 16
);
   logic                 START;
   logic [WIDTH_OUT-1:0] DATA_IN;
   logic [WIDTH_IN-1:0]  B_IN;
   logic [WIDTH_IN-1:0]  A_OUT;
   logic [WIDTH_IN-1:0]  C_OUT;
   logic                 VALID;
   logic                 BUSY;
   logic                 ERR_ZERO;
   logic                 ERR_RANGE;

   // consumer side: issues requests, receives decoded operands
   modport master (
      output START, DATA_IN, B_IN,
      input  A_OUT, C_OUT, VALID, BUSY, ERR_ZERO, ERR_RANGE
   );

   // decoder side
   modport slave (
      input  START, DATA_IN, B_IN,
      output A_OUT, C_OUT, VALID, BUSY, ERR_ZERO, ERR_RANGE
   );
endinterface

// File: rtl/registr_decode.sv
// Recovers A and C from DATA = A*B + C with a restoring shift-subtract divider,
// one quotient bit per clock. Returns the canonical pair A = DATA/B, C = DATA%B.
module registr_decode #(
   parameter int WIDTH_IN  = 8,
   parameter int WIDTH_OUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   registr_decode_if.slave     bus
);
   localparam int CNT_W = $clog2(WIDTH_OUT);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic [WIDTH_OUT-1:0] dividend;
   logic [WIDTH_IN-1:0]  divisor;
   logic [WIDTH_IN:0]    rem;
   logic [WIDTH_OUT-1:0] quot;
   logic [CNT_W-1:0]     cnt;
   logic                 zero_flag;

   logic [WIDTH_IN+1:0]  rem_shift;
   logic [WIDTH_IN:0]    rem_next;
   logic                 q_bit;

   // one restoring step: bring in the next dividend bit, subtract if it fits
   always_comb begin
      rem_shift = {rem, dividend[WIDTH_OUT-1]};
      q_bit     = 1'b0;
      rem_next  = (WIDTH_IN+1)'(rem_shift);
      if (rem_shift >= {2'b00, divisor}) begin
         q_bit    = 1'b1;
         rem_next = (WIDTH_IN+1)'(rem_shift - {2'b00, divisor});
      end
   end

   assign bus.BUSY = (state != IDLE);

   // control FSM, divider datapath and registered result outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         dividend      <= '0;
         divisor       <= '0;
         rem           <= '0;
         quot          <= '0;
         cnt           <= '0;
         zero_flag     <= 1'b0;
         bus.A_OUT     <= '0;
         bus.C_OUT     <= '0;
         bus.VALID     <= 1'b0;
         bus.ERR_ZERO  <= 1'b0;
         bus.ERR_RANGE <= 1'b0;
      end else begin
         bus.VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.START) begin
                  if (bus.B_IN == '0) begin
                     // nothing to iterate; report straight from DONE
                     zero_flag <= 1'b1;
                     state     <= DONE;
                  end else begin
                     zero_flag <= 1'b0;
                     dividend  <= bus.DATA_IN;
                     divisor   <= bus.B_IN;
                     rem       <= '0;
                     quot      <= '0;
                     cnt       <= CNT_W'(WIDTH_OUT-1);
                     state     <= RUN;
                  end
               end
            end
            RUN: begin
               rem      <= rem_next;
               dividend <= {dividend[WIDTH_OUT-2:0], 1'b0};
               quot     <= {quot[WIDTH_OUT-2:0], q_bit};
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - 1'b1;
            end
            DONE: begin
               bus.VALID <= 1'b1;
               if (zero_flag) begin
                  bus.A_OUT     <= '1;
                  bus.C_OUT     <= '0;
                  bus.ERR_ZERO  <= 1'b1;
                  bus.ERR_RANGE <= 1'b0;
               end else if (quot[WIDTH_OUT-1:WIDTH_IN] != '0) begin
                  // quotient too wide for A: saturate, remainder still exact
                  bus.A_OUT     <= '1;
                  bus.C_OUT     <= rem[WIDTH_IN-1:0];
                  bus.ERR_ZERO  <= 1'b0;
                  bus.ERR_RANGE <= 1'b1;
               end else begin
                  bus.A_OUT     <= quot[WIDTH_IN-1:0];
                  bus.C_OUT     <= rem[WIDTH_IN-1:0];
                  bus.ERR_ZERO  <= 1'b0;
                  bus.ERR_RANGE <= 1'b0;
               end
               zero_flag <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_registr_decode.sv
// Scoreboard bench for registr_decode: expected results queued at START, checked on VALID.
module tb_registr_decode;
   localparam int WI = 8;
   localparam int WO = 16;

   typedef struct {
      logic [WI-1:0] a;
      logic [WI-1:0] c;
      logic          ez;
      logic          er;
      int            lat;
      int            t0;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   int   valids = 0;
   int   exp_valids = 0;
   exp_t sb[$];

   registr_decode_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

   registr_decode #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // caller has already positioned between edges; START is sampled at the next edge
   task automatic start_op(input logic [WO-1:0] d, input logic [WI-1:0] b);
      exp_t e;
      int   q;
      bus.START   = 1'b1;
      bus.DATA_IN = d;
      bus.B_IN    = b;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      e.t0 = cyc;
      if (b == 0) begin
         e.a = '1; e.c = '0; e.ez = 1'b1; e.er = 1'b0; e.lat = 1;
      end else begin
         q    = int'(d) / int'(b);
         e.c  = WI'(int'(d) % int'(b));
         e.ez = 1'b0;
         e.er = (q > 255);
         e.a  = e.er ? 8'hFF : WI'(q);
         e.lat = WO + 1;
      end
      sb.push_back(e);
      exp_valids++;
   endtask

   task automatic wait_empty();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("timeout", sb.size(), 0);
      sb.delete();
   endtask

   // compare every VALID against the oldest outstanding expectation
   always @(negedge clk) begin
      if (!reset && bus.VALID) begin
         exp_t e;
         valids++;
         if (sb.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("a_out",     bus.A_OUT,     e.a);
            chk("c_out",     bus.C_OUT,     e.c);
            chk("err_zero",  bus.ERR_ZERO,  e.ez);
            chk("err_range", bus.ERR_RANGE, e.er);
            chk("latency",   cyc - e.t0,    e.lat);
         end
      end
   end

   initial begin
      bus.START   = 1'b0;
      bus.DATA_IN = '0;
      bus.B_IN    = '0;
      step();
      step();
      chk("rst_a",     bus.A_OUT,     0);
      chk("rst_c",     bus.C_OUT,     0);
      chk("rst_valid", bus.VALID,     0);
      chk("rst_busy",  bus.BUSY,      0);
      chk("rst_flags", {bus.ERR_ZERO, bus.ERR_RANGE}, 0);
      reset = 1'b0;
      step();

      // exact decode
      start_op(16'h7555, 8'd150);
      chk("busy_run", bus.BUSY, 1);
      wait_empty();

      // zero remainder, then a back-to-back request in the first IDLE cycle
      step();
      start_op(16'd3125, 8'd25);
      wait_empty();
      start_op(16'd0, 8'd7);
      wait_empty();

      // quotient overflow saturates
      step();
      start_op(16'hFFFF, 8'd2);
      wait_empty();

      // divide by zero: BUSY for exactly one cycle
      step();
      chk("busy_idle", bus.BUSY, 0);
      start_op(16'h1234, 8'd0);
      chk("busy_dz_on", bus.BUSY, 1);
      step();
      chk("busy_dz_off", bus.BUSY, 0);
      wait_empty();

      // START and operand changes during RUN are ignored
      step();
      start_op(16'd300, 8'd7);
      repeat (4) step();
      bus.START   = 1'b1;
      bus.DATA_IN = 16'd999;
      bus.B_IN    = 8'd3;
      step();
      bus.START = 1'b0;
      wait_empty();

      // reset mid-division drops the operation
      step();
      start_op(16'h7555, 8'd150);
      repeat (7) step();
      sb.delete();
      exp_valids--;
      reset = 1'b1;
      step();
      chk("mid_rst_a",     bus.A_OUT, 0);
      chk("mid_rst_c",     bus.C_OUT, 0);
      chk("mid_rst_busy",  bus.BUSY,  0);
      chk("mid_rst_valid", bus.VALID, 0);
      chk("mid_rst_flags", {bus.ERR_ZERO, bus.ERR_RANGE}, 0);
      reset = 1'b0;
      repeat (25) step();
      start_op(16'd100, 8'd10);
      wait_empty();

      // a few random operands
      for (int i = 0; i < 6; i++) begin
         step();
         start_op(WO'($urandom_range(0, 65535)), WI'($urandom_range(0, 255)));
         wait_empty();
      end

      repeat (5) step();
      chk("valid_count", valids, exp_valids);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
